// File: rtl/adder_pipe.sv
// adder_pipe: chunked ripple-carry adder/subtractor pipeline with valid/ready handshake
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   upstream handshake; transfer when both high
//   a, b, c_in, sub       operands, carry/borrow-in, 0=add 1=subtract
//   out_valid / out_ready downstream handshake
//   s, c_out, ovf         result, raw carry out, signed overflow
module adder_pipe #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             c_out,
    output logic             ovf
);
    localparam int STAGES = WIDTH / CHUNK;
    logic             adv;
    logic [WIDTH-1:0] a_i [STAGES];
    logic [WIDTH-1:0] b_i [STAGES];
    logic [WIDTH-1:0] s_i [STAGES];
    logic             c_i [STAGES];
    logic             v_i [STAGES];
    logic [WIDTH-1:0] a_q [STAGES];
    logic [WIDTH-1:0] b_q [STAGES];
    logic [WIDTH-1:0] s_q [STAGES];
    logic             c_q [STAGES];
    logic             v_q [STAGES];
    logic             o_q;
    // whole pipeline moves as one shift register, frozen only when the output is held
    assign adv       = !v_q[STAGES-1] || out_ready;
    assign in_ready  = adv;
    assign out_valid = v_q[STAGES-1];
    assign s         = s_q[STAGES-1];
    assign c_out     = c_q[STAGES-1];
    assign ovf       = o_q;
    // subtraction folds into addition of ~b with inverted carry-in at acceptance
    assign a_i[0] = a;
    assign b_i[0] = sub ? ~b : b;
    assign s_i[0] = '0;
    assign c_i[0] = c_in ^ sub;
    assign v_i[0] = in_valid;
    for (genvar k = 1; k < STAGES; k++) begin : g_link
        assign a_i[k] = a_q[k-1];
        assign b_i[k] = b_q[k-1];
        assign s_i[k] = s_q[k-1];
        assign c_i[k] = c_q[k-1];
        assign v_i[k] = v_q[k-1];
    end
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [CHUNK:0]   r;
        logic [WIDTH-1:0] s_n;
        assign r = {1'b0, a_i[k][k*CHUNK +: CHUNK]} + {1'b0, b_i[k][k*CHUNK +: CHUNK]}
                 + {{CHUNK{1'b0}}, c_i[k]};
        always_comb begin
            s_n = s_i[k];
            s_n[k*CHUNK +: CHUNK] = r[CHUNK-1:0];
        end
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v_q[k] <= 1'b0;
                c_q[k] <= 1'b0;
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
            end else if (adv) begin
                v_q[k] <= v_i[k];
                c_q[k] <= r[CHUNK];
                a_q[k] <= a_i[k];
                b_q[k] <= b_i[k];
                s_q[k] <= s_n;
            end
        end
        if (k == STAGES - 1) begin : g_ovf
            // same-sign operands producing an opposite-sign result
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) o_q <= 1'b0;
                else if (adv) o_q <= (a_i[k][WIDTH-1] == b_i[k][WIDTH-1]) && (r[CHUNK-1] != a_i[k][WIDTH-1]);
            end
        end
    end
endmodule

// File: tb/tb_adder_pipe.sv
// tb_adder_pipe: directed-vector and streaming checks for adder_pipe
module tb_adder_pipe;
    localparam int STAGES = 4;
    logic        clk = 0;
    logic        rst_n = 0;
    logic        in_valid = 0;
    logic        in_ready;
    logic [15:0] a = 0;
    logic [15:0] b = 0;
    logic        c_in = 0;
    logic        sub = 0;
    logic        out_valid;
    logic        out_ready = 1;
    logic [15:0] s;
    logic        c_out;
    logic        ovf;
    int checks = 0;
    int failures = 0;

    adder_pipe #(.WIDTH(16), .CHUNK(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .c_in(c_in), .sub(sub), .out_valid(out_valid),
        .out_ready(out_ready), .s(s), .c_out(c_out), .ovf(ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a, b;
        logic        ci, sb;
        logic [15:0] s;
        logic        c, o;
    } vec_t;

    vec_t tbl [10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // reference: {ovf, c_out, s}; ovf from carry into the msb xor carry out
    function automatic logic [17:0] model(input logic [15:0] x, input logic [15:0] y,
                                          input logic ci, input logic sb);
        logic [15:0] yy;
        logic [16:0] full;
        logic [15:0] low;
        yy   = sb ? ~y : y;
        full = {1'b0, x} + {1'b0, yy} + {16'd0, ci ^ sb};
        low  = {1'b0, x[14:0]} + {1'b0, yy[14:0]} + {15'd0, ci ^ sb};
        return {low[15] ^ full[16], full[16], full[15:0]};
    endfunction

    task automatic send_one(input vec_t v, input int idx);
        int cnt;
        @(posedge clk); #1;
        a = v.a; b = v.b; c_in = v.ci; sub = v.sb; in_valid = 1; out_ready = 1;
        @(posedge clk); #1;
        in_valid = 0;
        a = ~v.a; sub = ~v.sb; c_in = ~v.ci;
        cnt = 1;
        while (!out_valid && cnt < 12) begin
            @(posedge clk); #1;
            cnt++;
        end
        chk($sformatf("vec%0d_latency", idx), cnt, STAGES);
        chk($sformatf("vec%0d_result", idx), {ovf, c_out, s}, {v.o, v.c, v.s});
    endtask

    task automatic run_stream(input int n, input int bp_from, input int bp_len,
                              output int first_ov, output int ov_cnt, output int last_ov);
        logic [17:0] q [$];
        logic [18:0] pv;
        logic        ps;
        int sent, got, cyc;
        sent = 0; got = 0; cyc = 0; ps = 0; pv = 0;
        first_ov = -1; ov_cnt = 0; last_ov = -1;
        while (got < n && cyc < n + 100) begin
            @(posedge clk); #1;
            out_ready = !(cyc >= bp_from && cyc < bp_from + bp_len);
            in_valid  = sent < n;
            a = 16'($urandom); b = 16'($urandom); c_in = 1'($urandom); sub = 1'($urandom);
            #1;
            if (out_valid) begin
                if (first_ov < 0) first_ov = cyc;
                last_ov = cyc;
                ov_cnt++;
            end
            if (ps) chk("stall_hold", {13'd0, out_valid, ovf, c_out, s}, {13'd0, pv});
            if (out_valid && !out_ready) chk("stall_in_ready", {31'd0, in_ready}, 0);
            if (out_valid && out_ready) begin
                if (q.size() == 0) chk("stream_extra", {14'd0, ovf, c_out, s}, 32'hdead);
                else chk($sformatf("stream_res%0d", got), {14'd0, ovf, c_out, s}, {14'd0, q.pop_front()});
                got++;
            end
            if (in_valid && in_ready) begin
                q.push_back(model(a, b, c_in, sub));
                sent++;
            end
            ps = out_valid && !out_ready;
            pv = {out_valid, ovf, c_out, s};
            cyc++;
        end
        in_valid = 0;
        out_ready = 1;
        chk("stream_count", got, n);
    endtask

    initial begin
        int f, c, l, seen;
        tbl[0] = '{16'h1234, 16'h0FCD, 0, 0, 16'h2201, 0, 0};
        tbl[1] = '{16'hFFFF, 16'h0001, 0, 0, 16'h0000, 1, 0};
        tbl[2] = '{16'h7FFF, 16'h0001, 0, 0, 16'h8000, 0, 1};
        tbl[3] = '{16'h0005, 16'h0007, 0, 1, 16'hFFFE, 0, 0};
        tbl[4] = '{16'h8000, 16'h0001, 0, 1, 16'h7FFF, 1, 1};
        tbl[5] = '{16'h0000, 16'h0000, 1, 0, 16'h0001, 0, 0};
        tbl[6] = '{16'hFFFF, 16'hFFFF, 1, 0, 16'hFFFF, 1, 0};
        tbl[7] = '{16'h0000, 16'h0000, 1, 1, 16'hFFFF, 0, 0};
        tbl[8] = '{16'h8000, 16'h8000, 0, 0, 16'h0000, 1, 1};
        tbl[9] = '{16'h0F0F, 16'h00F1, 0, 0, 16'h1000, 0, 0};
        #1;
        chk("reset_out", {13'd0, out_valid, ovf, c_out, s}, 0);
        chk("reset_in_ready", {31'd0, in_ready}, 1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        chk("post_reset_in_ready", {31'd0, in_ready}, 1);
        for (int i = 0; i < 10; i++) send_one(tbl[i], i);
        run_stream(6, 2, 5, f, c, l);
        run_stream(100, 1000, 0, f, c, l);
        chk("thru_first", f, STAGES);
        chk("thru_count", c, 100);
        chk("thru_span", l - f, 99);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            in_valid = 1; a = 16'h1111 * 16'(i + 1); b = 16'h0101; c_in = 0; sub = 0;
        end
        @(posedge clk); #1;
        in_valid = 0;
        @(posedge clk); #1;
        chk("mid_pre_valid", {31'd0, out_valid}, 1);
        rst_n = 0;
        #1;
        chk("mid_reset_out", {13'd0, out_valid, ovf, c_out, s}, 0);
        chk("mid_reset_in_ready", {31'd0, in_ready}, 1);
        @(posedge clk); #1;
        rst_n = 1;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        chk("mid_no_ghost", seen, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
